// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit: forwarding selects, the load result source
// and the width of the outstanding multicycle-op counter.
package hazard_pkg;

  localparam logic [1:0] FWD_RF          = 2'b00;
  localparam logic [1:0] FWD_WB          = 2'b01;
  localparam logic [1:0] FWD_MEM         = 2'b10;
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  localparam int unsigned OUT_W   = 3;
  localparam logic [2:0]  OUT_MAX = 3'd7;

  // Which hazard sources fired this cycle; one bundle keeps the counter logic tidy.
  typedef struct packed {
    logic lw;
    logic mc;
    logic raw;
  } stall_src_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Busy bit per architectural register plus an outstanding-op counter for the
// variable-latency multicycle unit. A set and a clear on the same register: set wins.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int MC_DEPTH = 2
)(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   set_i,
  input  logic [REG_AW-1:0]      set_addr_i,
  input  logic                   clr_i,
  input  logic [REG_AW-1:0]      clr_addr_i,
  output logic [2**REG_AW-1:0]   busy_o,
  output logic                   full_o,
  output logic                   sb_err_o
);

  localparam int NREG = 2**REG_AW;

  logic [NREG-1:0]  busy_q, busy_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             err_q, err_d;

  // Next-state for busy bits; x0 can never be busy.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREG; i++) begin
      if (set_i && (set_addr_i == REG_AW'(i))) begin
        busy_d[i] = 1'b1;
      end else if (clr_i && (clr_addr_i == REG_AW'(i))) begin
        busy_d[i] = 1'b0;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
    busy_d[0] = 1'b0;
  end

  // Outstanding count and the sticky error for a completion nobody issued.
  always_comb begin
    out_d = out_q;
    case ({set_i, clr_i})
      2'b10:   out_d = (out_q == OUT_MAX) ? out_q : out_q + 3'd1;
      2'b01:   out_d = (out_q == 3'd0) ? out_q : out_q - 3'd1;
      default: out_d = out_q;
    endcase
    err_d = err_q | (clr_i & (out_q == 3'd0));
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0;
      out_q  <= 3'd0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      out_q  <= out_d;
      err_q  <= err_d;
    end
  end

  assign busy_o   = busy_q;
  assign full_o   = (out_q >= OUT_W'(MC_DEPTH));
  assign sb_err_o = err_q;

endmodule

// File: rtl/hazard_unit_sb.sv
// Hazard unit for the 5-stage pipeline: M/W forwarding, load-use and multicycle
// scoreboard stalls, branch flushes and saturating stall/flush counters.
module hazard_unit_sb
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int MC_DEPTH   = 2,
  parameter int ENABLE_FWD = 1,
  parameter int CNT_W      = 16
)(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] RdD,
  input  logic              McOpD,
  input  logic [REG_AW-1:0] rs1_addr_E,
  input  logic [REG_AW-1:0] rs2_addr_E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [1:0]        ResultSrcE,
  input  logic              RegWriteE,
  input  logic              PCSrcE,
  input  logic              McStartE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              McDoneW,
  input  logic [REG_AW-1:0] McRdW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              FlushE,
  output logic [CNT_W-1:0]  lw_stall_cnt,
  output logic [CNT_W-1:0]  mc_stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              sb_err
);

  localparam int NREG = 2**REG_AW;

  logic [NREG-1:0]  busy_s;
  logic             full_s;
  logic             sb_err_s;
  stall_src_t       src_s;
  logic             stall_s;
  logic [1:0]       fwd_a_s, fwd_b_s;
  logic [CNT_W-1:0] lw_cnt_q, lw_cnt_d;
  logic [CNT_W-1:0] mc_cnt_q, mc_cnt_d;
  logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;

  hazard_scoreboard #(
    .REG_AW   (REG_AW),
    .MC_DEPTH (MC_DEPTH)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_i      (McStartE),
    .set_addr_i (RdE),
    .clr_i      (McDoneW),
    .clr_addr_i (McRdW),
    .busy_o     (busy_s),
    .full_o     (full_s),
    .sb_err_o   (sb_err_s)
  );

  // A clear in W this cycle already releases the register to D via write-through.
  function automatic logic busy_live(input logic [NREG-1:0] busy,
                                     input logic [REG_AW-1:0] a,
                                     input logic done,
                                     input logic [REG_AW-1:0] done_a);
    return busy[a] & ~(done & (done_a == a));
  endfunction

  function automatic logic raw_hit(input logic [REG_AW-1:0] rs);
    return (rs != '0) && ((RegWriteE && (rs == RdE)) ||
                          (RegWriteM && (rs == RdM)) ||
                          (RegWriteW && (rs == RdW)));
  endfunction

  function automatic logic [1:0] fwd_pick(input logic [REG_AW-1:0] rs);
    if (RegWriteM && (RdM != '0) && (RdM == rs)) begin
      return FWD_MEM;
    end else if (RegWriteW && (RdW != '0) && (RdW == rs)) begin
      return FWD_WB;
    end else begin
      return FWD_RF;
    end
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + CNT_W'(1);
    end else begin
      return v;
    end
  endfunction

  // Classify this cycle's stall sources.
  always_comb begin
    src_s.lw = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != '0) &&
               ((Rs1D == RdE) || (Rs2D == RdE));
    src_s.mc = busy_live(busy_s, Rs1D, McDoneW, McRdW) ||
               busy_live(busy_s, Rs2D, McDoneW, McRdW) ||
               busy_live(busy_s, RdD,  McDoneW, McRdW) ||
               (McStartE && (RdE != '0) &&
                ((RdE == Rs1D) || (RdE == Rs2D) || (RdE == RdD))) ||
               (McOpD && full_s && !McDoneW);
    if (ENABLE_FWD == 0) begin
      src_s.raw = raw_hit(Rs1D) || raw_hit(Rs2D);
    end else begin
      src_s.raw = 1'b0;
    end
    stall_s = src_s.lw | src_s.mc | src_s.raw;
  end

  // Forward selects; without forwarding the stall covers every RAW instead.
  always_comb begin
    if (ENABLE_FWD != 0) begin
      fwd_a_s = fwd_pick(rs1_addr_E);
      fwd_b_s = fwd_pick(rs2_addr_E);
    end else begin
      fwd_a_s = FWD_RF;
      fwd_b_s = FWD_RF;
    end
  end

  // Pipeline controls, all quiet while reset is held.
  always_comb begin
    if (rst) begin
      ForwardAE = fwd_a_s;
      ForwardBE = fwd_b_s;
      StallF    = stall_s & ~PCSrcE;
      StallD    = stall_s & ~PCSrcE;
      FlushD    = PCSrcE;
      FlushE    = stall_s | PCSrcE;
    end else begin
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
    end
  end

  // Counter next-state; a taken branch is charged as a flush, not a stall.
  always_comb begin
    lw_cnt_d = sat_inc(lw_cnt_q, src_s.lw & ~PCSrcE);
    mc_cnt_d = sat_inc(mc_cnt_q, (src_s.mc | src_s.raw) & ~PCSrcE);
    fl_cnt_d = sat_inc(fl_cnt_q, PCSrcE);
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lw_cnt_q <= '0;
      mc_cnt_q <= '0;
      fl_cnt_q <= '0;
    end else begin
      lw_cnt_q <= lw_cnt_d;
      mc_cnt_q <= mc_cnt_d;
      fl_cnt_q <= fl_cnt_d;
    end
  end

  assign lw_stall_cnt = lw_cnt_q;
  assign mc_stall_cnt = mc_cnt_q;
  assign flush_cnt    = fl_cnt_q;
  assign sb_err       = sb_err_s;

endmodule

// File: tb/tb_hazard_unit_sb.sv
// Scoreboard bench: two DUTs (forwarding on / off with narrow counters) share stimulus;
// a behavioural model queues expected outputs that a negedge monitor compares.
module tb_hazard_unit_sb;

  localparam int AW = 5, DEPTH = 2, CW0 = 16, CW1 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, mcopd, rwe, pcsrce, mcstarte, rwm, rww, mcdonew;
  logic [AW-1:0] rs1d, rs2d, rdd, rs1e, rs2e, rde, rdm, rdw, mcrdw;
  logic [1:0] rsrce;

  logic [1:0] fa0, fb0, fa1, fb1;
  logic sf0, sd0, fd0, fe0, err0, sf1, sd1, fd1, fe1, err1;
  logic [CW0-1:0] lwc0, mcc0, flc0;
  logic [CW1-1:0] lwc1, mcc1, flc1;

  hazard_unit_sb #(.REG_AW(AW), .MC_DEPTH(DEPTH), .ENABLE_FWD(1), .CNT_W(CW0)) dut0 (
    .clk(clk), .rst(rst), .Rs1D(rs1d), .Rs2D(rs2d), .RdD(rdd), .McOpD(mcopd),
    .rs1_addr_E(rs1e), .rs2_addr_E(rs2e), .RdE(rde), .ResultSrcE(rsrce), .RegWriteE(rwe),
    .PCSrcE(pcsrce), .McStartE(mcstarte), .RdM(rdm), .RdW(rdw), .RegWriteM(rwm),
    .RegWriteW(rww), .McDoneW(mcdonew), .McRdW(mcrdw), .ForwardAE(fa0), .ForwardBE(fb0),
    .StallF(sf0), .StallD(sd0), .FlushD(fd0), .FlushE(fe0), .lw_stall_cnt(lwc0),
    .mc_stall_cnt(mcc0), .flush_cnt(flc0), .sb_err(err0));

  hazard_unit_sb #(.REG_AW(AW), .MC_DEPTH(DEPTH), .ENABLE_FWD(0), .CNT_W(CW1)) dut1 (
    .clk(clk), .rst(rst), .Rs1D(rs1d), .Rs2D(rs2d), .RdD(rdd), .McOpD(mcopd),
    .rs1_addr_E(rs1e), .rs2_addr_E(rs2e), .RdE(rde), .ResultSrcE(rsrce), .RegWriteE(rwe),
    .PCSrcE(pcsrce), .McStartE(mcstarte), .RdM(rdm), .RdW(rdw), .RegWriteM(rwm),
    .RegWriteW(rww), .McDoneW(mcdonew), .McRdW(mcrdw), .ForwardAE(fa1), .ForwardBE(fb1),
    .StallF(sf1), .StallD(sd1), .FlushD(fd1), .FlushE(fe1), .lw_stall_cnt(lwc1),
    .mc_stall_cnt(mcc1), .flush_cnt(flc1), .sb_err(err1));

  typedef struct {
    logic [1:0] fa, fb;
    logic sf, sd, fd, fe, err;
    int lw, mc, fl;
  } exp_t;
  typedef struct { exp_t e0; exp_t e1; } exp_pair_t;

  exp_pair_t q[$];
  int compared = 0, mismatched = 0;

  // Reference state: which registers await a multicycle result, and how many ops fly.
  bit busy_m[32];
  int outst_m, pend[$];
  bit err_m;
  int lw_m[2], mc_m[2], fl_m[2];

  function automatic int cmax(input int k);
    return (k == 0) ? (1 << CW0) - 1 : (1 << CW1) - 1;
  endfunction

  function automatic bit busy_hit(input logic [AW-1:0] r);
    return (r != 0) && busy_m[r] && !(mcdonew && mcrdw == r);
  endfunction

  function automatic bit raw_hit(input logic [AW-1:0] r);
    return (r != 0) && ((rwe && r == rde) || (rwm && r == rdm) || (rww && r == rdw));
  endfunction

  function automatic logic [1:0] fwd_exp(input logic [AW-1:0] r);
    if (rwm && rdm != 0 && rdm == r) return 2'b10;
    if (rww && rdw != 0 && rdw == r) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_step();
    exp_pair_t p;
    exp_t e;
    bit lws, mcs, raw, stall;
    for (int k = 0; k < 2; k++) begin
      lws = (rsrce == 2'b01) && (rde != 0) && (rs1d == rde || rs2d == rde);
      mcs = busy_hit(rs1d) || busy_hit(rs2d) || busy_hit(rdd) ||
            (mcstarte && rde != 0 && (rde == rs1d || rde == rs2d || rde == rdd)) ||
            (mcopd && outst_m == DEPTH && !mcdonew);
      raw = (k == 1) && (raw_hit(rs1d) || raw_hit(rs2d));
      stall = lws || mcs || raw;
      e.lw = lw_m[k]; e.mc = mc_m[k]; e.fl = fl_m[k]; e.err = err_m;
      if (!rst) begin
        e.fa = 2'b00; e.fb = 2'b00; e.sf = 1'b0; e.sd = 1'b0; e.fd = 1'b0; e.fe = 1'b0;
        lw_m[k] = 0; mc_m[k] = 0; fl_m[k] = 0;
      end else begin
        e.fa = (k == 0) ? fwd_exp(rs1e) : 2'b00;
        e.fb = (k == 0) ? fwd_exp(rs2e) : 2'b00;
        e.sf = stall && !pcsrce; e.sd = stall && !pcsrce;
        e.fd = pcsrce; e.fe = stall || pcsrce;
        if (lws && !pcsrce && lw_m[k] < cmax(k)) lw_m[k]++;
        if ((mcs || raw) && !pcsrce && mc_m[k] < cmax(k)) mc_m[k]++;
        if (pcsrce && fl_m[k] < cmax(k)) fl_m[k]++;
      end
      if (k == 0) p.e0 = e; else p.e1 = e;
    end
    q.push_back(p);
    if (!rst) begin
      foreach (busy_m[i]) busy_m[i] = 1'b0;
      outst_m = 0; err_m = 1'b0; pend.delete();
    end else begin
      if (mcdonew) begin
        if (outst_m == 0) err_m = 1'b1;
        busy_m[mcrdw] = 1'b0;
        for (int i = 0; i < pend.size(); i++)
          if (pend[i] == int'(mcrdw)) begin pend.delete(i); break; end
      end
      if (mcstarte) begin
        if (rde != 0) busy_m[rde] = 1'b1;
        pend.push_back(int'(rde));
      end
      if (mcstarte && !mcdonew && outst_m < 7) outst_m++;
      else if (!mcstarte && mcdonew && outst_m > 0) outst_m--;
    end
  endtask

  task automatic idle();
    rst = 1'b1; mcopd = 1'b0; rwe = 1'b0; pcsrce = 1'b0; mcstarte = 1'b0;
    rwm = 1'b0; rww = 1'b0; mcdonew = 1'b0; rsrce = 2'b00;
    rs1d = '0; rs2d = '0; rdd = '0; rs1e = '0; rs2e = '0; rde = '0; rdm = '0; rdw = '0; mcrdw = '0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_pair_t p;
      p = q.pop_front();
      chk("fwdA0", 32'(fa0), 32'(p.e0.fa));  chk("fwdB0", 32'(fb0), 32'(p.e0.fb));
      chk("stallF0", 32'(sf0), 32'(p.e0.sf)); chk("stallD0", 32'(sd0), 32'(p.e0.sd));
      chk("flushD0", 32'(fd0), 32'(p.e0.fd)); chk("flushE0", 32'(fe0), 32'(p.e0.fe));
      chk("lwcnt0", 32'(lwc0), p.e0.lw);      chk("mccnt0", 32'(mcc0), p.e0.mc);
      chk("flcnt0", 32'(flc0), p.e0.fl);      chk("sberr0", 32'(err0), 32'(p.e0.err));
      chk("fwdA1", 32'(fa1), 32'(p.e1.fa));  chk("fwdB1", 32'(fb1), 32'(p.e1.fb));
      chk("stallF1", 32'(sf1), 32'(p.e1.sf)); chk("stallD1", 32'(sd1), 32'(p.e1.sd));
      chk("flushD1", 32'(fd1), 32'(p.e1.fd)); chk("flushE1", 32'(fe1), 32'(p.e1.fe));
      chk("lwcnt1", 32'(lwc1), p.e1.lw);      chk("mccnt1", 32'(mcc1), p.e1.mc);
      chk("flcnt1", 32'(flc1), p.e1.fl);      chk("sberr1", 32'(err1), 32'(p.e1.err));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit injected;
    idle();
    rst = 1'b0;
    outst_m = 0; err_m = 1'b0;
    for (int k = 0; k < 2; k++) begin lw_m[k] = 0; mc_m[k] = 0; fl_m[k] = 0; end
    @(posedge clk); @(posedge clk); #1;

    // load-use on x5, then a load to x0 that must not stall
    idle(); rsrce = 2'b01; rde = 5'd5; rs1d = 5'd5; step();
    idle(); step();
    idle(); rsrce = 2'b01; rde = 5'd0; rs1d = 5'd0; step();
    // M/W forwarding priority; non-forwarding instance stalls until x7 leaves W
    idle(); rwm = 1'b1; rdm = 5'd7; rww = 1'b1; rdw = 5'd7; rs1e = 5'd7; rs2e = 5'd7; rs1d = 5'd7; step();
    rwm = 1'b0; step();
    rww = 1'b0; step();
    // multicycle result x9 blocks D until its completion cycle
    idle(); mcstarte = 1'b1; rde = 5'd9; step();
    idle(); rs1d = 5'd9; repeat (3) step();
    mcdonew = 1'b1; mcrdw = 5'd9; step();
    // depth-full stall, released by a same-cycle completion
    idle(); mcstarte = 1'b1; rde = 5'd10; step(); rde = 5'd11; step();
    idle(); mcopd = 1'b1; step();
    mcdonew = 1'b1; mcrdw = 5'd10; step();
    idle(); mcdonew = 1'b1; mcrdw = 5'd11; step();
    // load-use under a taken branch, then a spurious completion
    idle(); rsrce = 2'b01; rde = 5'd5; rs2d = 5'd5; pcsrce = 1'b1; step();
    idle(); mcdonew = 1'b1; mcrdw = 5'd3; step();
    idle(); step(); step();
    // reset with x9 busy and counters nonzero
    idle(); mcstarte = 1'b1; rde = 5'd9; step();
    idle(); rst = 1'b0; step();
    idle(); rs1d = 5'd9; step(); step();

    for (int n = 0; n < 3000; n++) begin
      idle();
      rst = ($urandom_range(0, 199) != 0);
      rs1d = AW'($urandom_range(0, 7)); rs2d = AW'($urandom_range(0, 7));
      rdd = AW'($urandom_range(0, 7));  rs1e = AW'($urandom_range(0, 7));
      rs2e = AW'($urandom_range(0, 7)); rde = AW'($urandom_range(0, 7));
      rdm = AW'($urandom_range(0, 7));  rdw = AW'($urandom_range(0, 7));
      rsrce = 2'($urandom_range(0, 3)); mcopd = 1'($urandom_range(0, 1));
      rwe = 1'($urandom_range(0, 1)); rwm = 1'($urandom_range(0, 1));
      rww = 1'($urandom_range(0, 1)); pcsrce = ($urandom_range(0, 7) == 0);
      injected = 1'b0;
      if (pend.size() > 0 && $urandom_range(0, 2) == 0) begin
        mcdonew = 1'b1;
        mcrdw = AW'(pend[$urandom_range(0, pend.size() - 1)]);
      end else if (outst_m == 0 && $urandom_range(0, 49) == 0) begin
        mcdonew = 1'b1; mcrdw = AW'($urandom_range(0, 7)); injected = 1'b1;
      end
      if (!injected && outst_m < DEPTH && $urandom_range(0, 2) == 0) mcstarte = 1'b1;
      step();
    end

    idle();
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      compared++; mismatched++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hazard_unit_sb.md
# hazard_unit_sb

Parametrised next-generation hazard unit for the 5-stage RISC-V pipeline (F/D/E/M/W). It keeps M/W→E operand forwarding and load-use stalling, and adds control-hazard flushing on taken branches/jumps. It also adds a register scoreboard for a variable-latency multicycle unit (mul/div) and saturating stall/flush performance counters. It sits beside the datapath and drives the F/D pipeline-register enables and the D/E flushes.

## Interface
Parameters:
- REG_AW, 5: register address width; register count is 2**REG_AW.
- MC_DEPTH, 2: maximum outstanding multicycle ops, 1..7.
- ENABLE_FWD, 1: 1 forwards from M/W; 0 stalls D on any RAW hit in E/M/W instead.
- CNT_W, 16: performance counter width.

Ports:
- clk  input  1  pipeline clock
- rst  input  1  synchronous, active-low reset
- Rs1D, Rs2D, RdD  input  REG_AW  D-stage source/dest addresses
- McOpD  input  1  D-stage instruction is a multicycle op
- rs1_addr_E, rs2_addr_E, RdE  input  REG_AW  E-stage addresses
- ResultSrcE  input  2  2'b01 = load
- RegWriteE  input  1  E-stage writes a register (used when ENABLE_FWD=0)
- PCSrcE  input  1  taken branch/jump resolved in E
- McStartE  input  1  multicycle op issues from E this cycle, dest RdE
- RdM, RdW  input  REG_AW; RegWriteM, RegWriteW  input  1
- McDoneW  input  1  multicycle result written back this cycle, dest McRdW
- McRdW  input  REG_AW
- ForwardAE, ForwardBE  output  2  00 regfile, 01 W, 10 M
- StallF, StallD, FlushD, FlushE  output  1
- lw_stall_cnt, mc_stall_cnt, flush_cnt  output  CNT_W  saturating counters
- sb_err  output  1  sticky: McDoneW seen with no outstanding op

## Operation
- Forwarding (ENABLE_FWD=1): identical priority M over W. Match requires RegWrite=1 and Rd≠0. Outputs 00 while rst=0.
- lwstall = ResultSrcE==01 & RdE≠0 & (Rs1D==RdE | Rs2D==RdE). An x0 destination never stalls.
- rawstall (ENABLE_FWD=0 only): a nonzero Rs1D/Rs2D equals RdE, RdM or RdW with the corresponding RegWrite set. ForwardAE/BE are held at 00.
- Scoreboard: one busy bit per register, bit 0 hardwired 0.
  - McStartE & RdE≠0 sets busy[RdE] at the clock edge.
  - McDoneW clears busy[McRdW].
  - Same register set and cleared in one cycle: set wins.
- mcstall is asserted when any of the following holds:
  - busy[Rs1D], busy[Rs2D] or busy[RdD] (WAW) is set, and the matching register is not being cleared by McDoneW this cycle.
  - McStartE with a nonzero RdE matching Rs1D/Rs2D/RdD.
  - McOpD while outstanding==MC_DEPTH and no McDoneW this cycle.
- outstanding counter (3 bits): +1 on McStartE, −1 on McDoneW, unchanged when both occur. McDoneW at 0 leaves it at 0 and sets sb_err.
- stall = lwstall | mcstall | rawstall.
- StallF = StallD = stall & ~PCSrcE, because a taken branch discards D anyway.
- FlushD = PCSrcE. FlushE = stall | PCSrcE.
- Counters, each saturating at all-ones:
  - lw_stall_cnt +1 per cycle with lwstall & ~PCSrcE.
  - mc_stall_cnt +1 per cycle with (mcstall|rawstall) & ~PCSrcE.
  - flush_cnt +1 per cycle with PCSrcE.

## Timing
- All stall/flush/forward outputs are combinational from the current inputs and registered state, with zero-cycle latency.
- Scoreboard and counters update on the rising clk edge. A set is visible to D in the next cycle; the same-cycle case is covered by the McStartE term.
- A clear by McDoneW is effective in the same cycle. W-stage forwarding supplies the E operand, and the regfile write-through supplies D.
- rst=0 at an edge clears:
  - busy bits, outstanding, counters, sb_err.
  - Any in-flight op is forgotten; the pipeline is flushed by the same reset.
- While rst=0, all stall/flush outputs are 0 and forwards are 00.

## Structure
- Package hazard_pkg:
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - RESULT_SRC_LOAD=2'b01.
- Sub-module hazard_scoreboard holds busy bits, outstanding counter and sb_err. Parameters REG_AW and MC_DEPTH; outputs are the busy vector and full.
- Counters stay in the top level.

## Test plan
- Load x5 in E, D reads x5 → StallF=StallD=FlushE=1 for 1 cycle, lw_stall_cnt=1. Load x0 in E, D reads x0 → no stall.
- RegWriteM=1, RdM=x7, RegWriteW=1, RdW=x7, rs1_addr_E=x7 → ForwardAE=10. Drop RegWriteM → 01. ENABLE_FWD=0 → D stalls until x7 leaves W.
- McStartE RdE=x9, then D reads x9 → stall every cycle until McDoneW McRdW=x9. In the McDoneW cycle StallD=0, and mc_stall_cnt equals the stall cycles.
- MC_DEPTH=2, two McStartE, then McOpD → stall. McOpD in the same cycle as McDoneW → no stall.
- lwstall and PCSrcE together → StallF=StallD=0, FlushD=FlushE=1, flush_cnt+1. McDoneW with outstanding=0 → sb_err=1 until rst.
- Reset asserted with busy[x9]=1 and counters nonzero → next cycle busy=0, counters=0, and D reading x9 does not stall.
